// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared types and helpers for the async_fifo write-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Index/counter width that stays at least one bit even for n <= 2.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rr_pick
// Description : Combinational rotate-priority picker; first set bit at or
//               after rr_ptr, scanning upward and wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [PTR_W-1:0]   sel,
    output logic               any
);

    logic [PTR_W-1:0] w_idx;

    function automatic int wrap_idx(input int i);
        return (i >= NUM_REQ) ? i - NUM_REQ : i;
    endfunction

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        sel   = '0;
        w_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = PTR_W'(wrap_idx(int'(rr_ptr) + k));
            if (req[w_idx]) begin
                sel = w_idx;
            end
        end
    end

    assign any = |req;

endmodule
`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_arbiter
// Description : Round-robin burst arbiter sharing the async_fifo write port
//               between NUM_REQ requesters in the write clock domain.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATASIZE  = 8,
    parameter int MAX_BURST = 4,
    localparam int OWN_W    = clog2_min1(NUM_REQ)
) (
    input  logic                        write_clk,
    input  logic                        write_reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATASIZE-1:0] req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          accept,
    output logic                        write_enable,
    output logic [DATASIZE-1:0]         write_data,
    input  logic                        write_full,
    output logic                        busy,
    output logic [OWN_W-1:0]            owner
);

    localparam int               CNT_W     = clog2_min1(MAX_BURST);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [OWN_W-1:0] LAST_REQ  = OWN_W'(NUM_REQ - 1);

    arb_state_t         state_q,    state_d;
    logic [NUM_REQ-1:0] gnt_q,      gnt_d;
    logic [OWN_W-1:0]   owner_q,    owner_d;
    logic [OWN_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic [OWN_W-1:0]    w_pick_sel;
    logic                w_pick_any;
    logic                w_own_req;
    logic                w_own_last;
    logic [DATASIZE-1:0] w_own_data;
    logic                w_xfer;
    logic                w_release;

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (OWN_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .sel    (w_pick_sel),
        .any    (w_pick_any)
    );

    always_comb begin
        w_own_req  = 1'b0;
        w_own_last = 1'b0;
        w_own_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == OWN_W'(i)) begin
                w_own_req  = req[i];
                w_own_last = req_last[i];
                w_own_data = req_data[i*DATASIZE +: DATASIZE];
            end
        end
    end

    // A withdrawn request releases the grant even though nothing transfers.
    assign w_xfer    = (state_q == BURST) & w_own_req & ~write_full;
    assign w_release = (state_q == BURST) &
                       (~w_own_req | (w_xfer & (w_own_last | (beat_cnt_q == LAST_BEAT))));

    always_ff @(posedge write_clk or posedge write_reset) begin
        if (write_reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (w_pick_any) begin
                    state_d    = BURST;
                    owner_d    = w_pick_sel;
                    beat_cnt_d = '0;
                    gnt_d      = '0;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (w_pick_sel == OWN_W'(i)) begin
                            gnt_d[i] = 1'b1;
                        end
                    end
                end
            end
            BURST: begin
                if (w_release) begin
                    state_d    = IDLE;
                    gnt_d      = '0;
                    beat_cnt_d = '0;
                    rr_ptr_d   = (owner_q == LAST_REQ) ? '0 : owner_q + OWN_W'(1);
                end else if (w_xfer) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        busy         = (state_q == BURST);
        gnt          = gnt_q;
        owner        = owner_q;
        write_enable = w_xfer;
        write_data   = (gnt_q != '0) ? w_own_data : '0;
        accept       = w_xfer ? gnt_q : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_write_arbiter
// Description : Scoreboard bench for fifo_write_arbiter with directed and
//               randomized requester traffic and write_full back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            write_clk = 1'b0;
    logic            write_reset;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    gnt;
    logic [N-1:0]    accept;
    logic            write_enable;
    logic [DW-1:0]   write_data;
    logic            write_full;
    logic            busy;
    logic [1:0]      owner;

    int n_checks = 0;
    int n_err    = 0;

    // Requester-side word queues and per-requester expected write streams.
    logic [DW-1:0] dq_d [N][$];
    bit            dq_l [N][$];
    logic [DW-1:0] sb   [N][$];
    logic [N-1:0]  acc_seen;
    logic [N-1:0]  hold_off;
    bit            rnd_wd;

    // Reference model state: who should own the port, burst progress, rr pointer.
    int  m_busy, m_owner, m_ptr, m_beats;
    int  glog[$];
    int  blog[$];
    bit  exp_we, rel;
    int  pk;

    fifo_write_arbiter #(
        .NUM_REQ   (N),
        .DATASIZE  (DW),
        .MAX_BURST (MB)
    ) dut (
        .write_clk    (write_clk),
        .write_reset  (write_reset),
        .req          (req),
        .req_data     (req_data),
        .req_last     (req_last),
        .gnt          (gnt),
        .accept       (accept),
        .write_enable (write_enable),
        .write_data   (write_data),
        .write_full   (write_full),
        .busy         (busy),
        .owner        (owner)
    );

    always #5 write_clk = ~write_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic push_word(input int r, input logic [DW-1:0] d, input bit l);
        dq_d[r].push_back(d);
        dq_l[r].push_back(l);
        sb[r].push_back(d);
    endtask

    task automatic clear_logs();
        glog.delete();
        blog.delete();
    endtask

    // One clock of requester behaviour: retire accepted words, present the next.
    task automatic step(input logic full);
        @(posedge write_clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_seen[i] && dq_d[i].size() > 0) begin
                void'(dq_d[i].pop_front());
                void'(dq_l[i].pop_front());
            end
        end
        for (int i = 0; i < N; i++) begin
            if (dq_d[i].size() > 0 && !hold_off[i] &&
                !(rnd_wd && $urandom_range(0, 99) < 10)) begin
                req[i]              = 1'b1;
                req_data[i*DW +: DW] = dq_d[i][0];
                req_last[i]         = dq_l[i][0];
            end else begin
                req[i]              = 1'b0;
                req_data[i*DW +: DW] = DW'($urandom);
                req_last[i]         = 1'($urandom);
            end
        end
        write_full = full;
    endtask

    task automatic do_reset();
        write_reset = 1'b1;
        req         = '0;
        req_last    = '0;
        req_data    = '0;
        write_full  = 1'b0;
        hold_off    = '0;
        for (int i = 0; i < N; i++) begin
            dq_d[i].delete();
            dq_l[i].delete();
            sb[i].delete();
        end
        repeat (2) @(posedge write_clk);
        #1 write_reset = 1'b0;
    endtask

    // Monitor: compares DUT outputs against the model and pops the scoreboard.
    initial begin
        m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
        forever begin
            @(negedge write_clk);
            acc_seen = accept;
            if (write_reset) begin
                m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
            end else begin
                exp_we = (m_busy != 0) && req[m_owner] && !write_full;
                chk("busy", 64'(busy), 64'(m_busy != 0));
                chk("gnt", 64'(gnt), (m_busy != 0) ? (64'd1 << m_owner) : 64'd0);
                if (m_busy != 0) chk("owner", 64'(owner), 64'(m_owner));
                chk("write_enable", 64'(write_enable), 64'(exp_we));
                chk("accept", 64'(accept), exp_we ? (64'd1 << m_owner) : 64'd0);
                if (write_enable && exp_we) begin
                    if (sb[m_owner].size() == 0)
                        chk("sb_has_word", 64'(sb[m_owner].size() > 0), 64'd1);
                    else
                        chk("write_data", 64'(write_data), 64'(sb[m_owner].pop_front()));
                end
                if (m_busy != 0) begin
                    if (exp_we) m_beats++;
                    rel = !req[m_owner] || (exp_we && (req_last[m_owner] || m_beats == MB));
                    if (rel) begin
                        blog.push_back(m_beats);
                        m_busy = 0;
                        m_ptr  = (m_owner + 1) % N;
                    end
                end else begin
                    pk = rr_pick(req, m_ptr);
                    if (pk >= 0) begin
                        m_busy  = 1;
                        m_owner = pk;
                        m_beats = 0;
                        glog.push_back(pk);
                    end
                end
            end
        end
    end

    initial begin
        int left;
        write_reset = 1'b1;
        req         = '0;
        req_last    = '0;
        req_data    = '0;
        write_full  = 1'b0;
        hold_off    = '0;
        rnd_wd      = 1'b0;
        #1;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_we", 64'(write_enable), 64'd0);
        chk("rst_wdata", 64'(write_data), 64'd0);
        chk("rst_accept", 64'(accept), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_owner", 64'(owner), 64'd0);
        do_reset();

        // Idle with no requests, then an asynchronous reset in mid-burst.
        repeat (10) step(1'b0);
        for (int w = 0; w < 4; w++) push_word(0, DW'(8'h10 + w), 1'b0);
        repeat (3) step(1'b0);
        chk("pre_reset_busy", 64'(busy), 64'd1);
        #2 write_reset = 1'b1;
        #1;
        chk("midrst_gnt", 64'(gnt), 64'd0);
        chk("midrst_we", 64'(write_enable), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        do_reset();

        // Six words from requester 1: a full burst, one idle cycle, then two more.
        clear_logs();
        for (int w = 0; w < 6; w++) push_word(1, DW'(8'hA0 + w), w == 5);
        repeat (14) step(1'b0);
        chk("six_grants", 64'(glog.size()), 64'd2);
        chk("six_owner0", 64'(glog[0]), 64'd1);
        chk("six_owner1", 64'(glog[1]), 64'd1);
        chk("six_burst0", 64'(blog[0]), 64'd4);
        chk("six_burst1", 64'(blog[1]), 64'd2);
        chk("six_drained", 64'(sb[1].size()), 64'd0);

        // All four requesting, every word marked last: strict rotation.
        do_reset();
        clear_logs();
        push_word(0, 8'h01, 1'b1);
        push_word(0, 8'h05, 1'b1);
        for (int r = 1; r < N; r++) push_word(r, DW'(r + 1), 1'b1);
        repeat (16) step(1'b0);
        chk("rot_grants", 64'(glog.size()), 64'd5);
        for (int g = 0; g < 5; g++) begin
            chk("rot_order", 64'(glog[g]), 64'(g % N));
            chk("rot_one_beat", 64'(blog[g]), 64'd1);
        end

        // Requester 2 stalled by write_full for five cycles after its first beat.
        do_reset();
        clear_logs();
        for (int w = 0; w < 4; w++) push_word(2, DW'(8'h20 + w), 1'b0);
        repeat (2) step(1'b0);
        repeat (5) step(1'b1);
        repeat (8) step(1'b0);
        chk("full_grants", 64'(glog.size()), 64'd1);
        chk("full_owner", 64'(glog[0]), 64'd2);
        chk("full_burst", 64'(blog[0]), 64'd4);
        chk("full_drained", 64'(sb[2].size()), 64'd0);

        // Requester 3 withdraws after two beats; pending requester 1 goes next.
        do_reset();
        clear_logs();
        for (int w = 0; w < 4; w++) push_word(3, DW'(8'h30 + w), 1'b0);
        repeat (3) step(1'b0);
        hold_off[3] = 1'b1;
        push_word(1, 8'h40, 1'b0);
        push_word(1, 8'h41, 1'b1);
        repeat (2) step(1'b0);
        hold_off[3] = 1'b0;
        repeat (12) step(1'b0);
        chk("wd_first", 64'(glog[0]), 64'd3);
        chk("wd_second", 64'(glog[1]), 64'd1);
        chk("wd_third", 64'(glog[2]), 64'd3);
        chk("wd_burst0", 64'(blog[0]), 64'd2);
        chk("wd_drain1", 64'(sb[1].size()), 64'd0);
        chk("wd_drain3", 64'(sb[3].size()), 64'd0);

        // Randomized traffic: three requesters, 100 words each, random back-pressure.
        do_reset();
        clear_logs();
        rnd_wd = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int w = 0; w < 100; w++) push_word(r, DW'($urandom), $urandom_range(0, 3) == 0);
        end
        left = 300;
        for (int c = 0; c < 6000 && left > 0; c++) begin
            step($urandom_range(0, 99) < 30);
            left = dq_d[0].size() + dq_d[1].size() + dq_d[2].size();
        end
        rnd_wd = 1'b0;
        repeat (3) step(1'b0);
        chk("rnd_words_left", 64'(left), 64'd0);
        for (int r = 0; r < 3; r++) chk("rnd_sb_empty", 64'(sb[r].size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
